// File: rtl/multicycle_datapath.sv
// multicycle_datapath
//   Multi-cycle core datapath: register file, PC, NZCV flags, ALU and a
//   FETCH/DECODE/EXEC/MEM/WB sequencer. It talks to instruction and data
//   memories over req/ready handshakes, so wait-state memories are supported.
// Ports
//   clk, rst                  clock; synchronous active-low reset
//   run                       start next fetch when 1; idle in FETCH when 0
//   imem_req/addr/ready/rdata instruction fetch handshake (addr = pc)
//   dmem_req/we/addr/wdata    data access request, held until dmem_ready
//   dmem_ready/rdata          data access complete / load data
//   pc, flags                 architectural PC and {N,Z,C,V}
//   retire                    one-cycle pulse per completed instruction
//   illegal                   sticky undefined-opcode indicator
module multicycle_datapath #(
  parameter int unsigned       XLEN     = 32,
  parameter int unsigned       NREGS    = 16,
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ready,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        flags,
  output logic              retire,
  output logic              illegal
);

  localparam int unsigned RW = $clog2(NREGS);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;
  typedef enum logic [4:0] {
    OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_ORR = 5'd3,
    OP_EOR = 5'd4, OP_MOV = 5'd5, OP_CMP = 5'd6, OP_LDR = 5'd7,
    OP_STR = 5'd8, OP_B   = 5'd9, OP_BL  = 5'd10, OP_NOP = 5'd31
  } op_e;

  state_e            state;
  logic [31:0]       ir;
  logic [XLEN-1:0]   regs [NREGS];
  logic [XLEN-1:0]   a_q, b_q, d_q, res_q;
  logic [3:0]        nflags_q;
  logic              fen_q, wen_q, ill_q;
  logic [RW-1:0]     widx_q;
  logic [ADDR_W-1:0] npc_q;

  op_e               op;
  logic [XLEN-1:0]   op2, alu_res;
  logic [XLEN:0]     sum_add, sum_sub;
  logic [1:0]        cv;
  logic              flag_en, reg_wen, is_mem, is_bad;
  logic [RW-1:0]     widx;
  logic [ADDR_W-1:0] pc4, br_target, next_pc;

  logic unused_ir;
  assign unused_ir = ir[12];

  assign op        = op_e'(ir[31:27]);
  assign imem_addr = pc;

  // Execute-stage combinational logic: operands come from the DECODE latches.
  always_comb begin
    op2       = ir[14] ? XLEN'(ir[11:0]) : b_q;
    sum_add   = {1'b0, a_q} + {1'b0, op2};
    sum_sub   = {1'b0, a_q} + {1'b0, ~op2} + {{XLEN{1'b0}}, 1'b1};
    pc4       = pc + ADDR_W'(4);
    // sign-extended word offset, wrapped to the PC width
    br_target = pc4 + ADDR_W'({{ADDR_W{ir[22]}}, ir[22:0], 2'b00});
    alu_res   = '0;
    cv        = flags[1:0];
    flag_en   = 1'b0;
    reg_wen   = 1'b0;
    is_mem    = 1'b0;
    is_bad    = 1'b0;
    widx      = ir[23 +: RW];
    next_pc   = pc4;
    case (op)
      OP_ADD: begin
        alu_res = sum_add[XLEN-1:0];
        cv      = {sum_add[XLEN],
                   (a_q[XLEN-1] == op2[XLEN-1]) && (sum_add[XLEN-1] != a_q[XLEN-1])};
        flag_en = ir[13];
        reg_wen = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        alu_res = sum_sub[XLEN-1:0];
        cv      = {sum_sub[XLEN],
                   (a_q[XLEN-1] != op2[XLEN-1]) && (sum_sub[XLEN-1] != a_q[XLEN-1])};
        flag_en = ir[13] || (op == OP_CMP);
        reg_wen = (op == OP_SUB);
      end
      OP_AND: begin alu_res = a_q & op2; flag_en = ir[13]; reg_wen = 1'b1; end
      OP_ORR: begin alu_res = a_q | op2; flag_en = ir[13]; reg_wen = 1'b1; end
      OP_EOR: begin alu_res = a_q ^ op2; flag_en = ir[13]; reg_wen = 1'b1; end
      OP_MOV: begin alu_res = op2;       flag_en = ir[13]; reg_wen = 1'b1; end
      OP_LDR: begin is_mem = 1'b1; reg_wen = 1'b1; end
      OP_STR: is_mem = 1'b1;
      OP_B:   next_pc = br_target;
      OP_BL: begin
        next_pc = br_target;
        alu_res = XLEN'(pc4);
        reg_wen = 1'b1;
        widx    = '1;
      end
      OP_NOP: ;
      default: is_bad = 1'b1;
    endcase
  end

  // imem_req is registered: it follows run while idling in FETCH and is
  // pre-armed in WB so back-to-back instructions fetch without a bubble.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      flags      <= '0;
      illegal    <= 1'b0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      retire     <= 1'b0;
      regs       <= '{default: '0};
    end else begin
      retire <= 1'b0;
      case (state)
        S_FETCH: begin
          if (imem_req) begin
            if (imem_ready) begin
              ir       <= imem_rdata;
              imem_req <= 1'b0;
              state    <= S_DECODE;
            end
          end else begin
            imem_req <= run;
          end
        end
        S_DECODE: begin
          a_q   <= regs[ir[19 +: RW]];
          b_q   <= regs[ir[15 +: RW]];
          d_q   <= regs[ir[23 +: RW]];
          state <= S_EXEC;
        end
        S_EXEC: begin
          res_q    <= alu_res;
          nflags_q <= {alu_res[XLEN-1], alu_res == '0, cv};
          fen_q    <= flag_en;
          wen_q    <= reg_wen;
          widx_q   <= widx;
          npc_q    <= next_pc;
          ill_q    <= is_bad;
          if (is_mem) begin
            dmem_req   <= 1'b1;
            dmem_we    <= (op == OP_STR);
            dmem_addr  <= ADDR_W'(sum_add[XLEN-1:0]);
            dmem_wdata <= d_q;
            state      <= S_MEM;
          end else begin
            retire <= 1'b1;
            state  <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (!dmem_we) res_q <= dmem_rdata;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            retire   <= 1'b1;
            state    <= S_WB;
          end
        end
        S_WB: begin
          if (wen_q) regs[widx_q] <= res_q;
          if (fen_q) flags <= nflags_q;
          if (ill_q) illegal <= 1'b1;
          pc       <= npc_q;
          imem_req <= run;
          state    <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath
//   Directed bench for multicycle_datapath: zero-wait instruction memory,
//   data memory with programmable wait states, hand-computed expectations.
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] pc;
  logic [3:0]  flags;
  logic        retire, illegal;

  int total = 0;
  int bad   = 0;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  int          dmem_delay = 0;
  int          dcnt;
  logic        moved;
  int          st_cnt;
  logic [31:0] st_addr, st_data;
  logic [31:0] h_addr, h_wdata;
  logic        h_we;

  multicycle_datapath #(.XLEN(32), .NREGS(16), .ADDR_W(32), .RESET_PC(32'h4)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .pc(pc), .flags(flags), .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] rd,
                                      input logic [3:0] rn, input logic [3:0] rm,
                                      input logic i, input logic s, input logic [11:0] imm);
    return {op, rd, rn, rm, i, s, 1'b0, imm};
  endfunction

  function automatic logic [31:0] enc_b(input logic [4:0] op, input logic [22:0] off);
    return {op, 4'd0, off};
  endfunction

  // zero-wait instruction memory
  initial begin
    imem_ready = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      imem_ready = imem_req;
      imem_rdata = imem[imem_addr[7:2]];
    end
  end

  // data memory with dmem_delay wait cycles; also watches request stability
  initial begin
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    dcnt = 0; moved = 1'b0; st_cnt = 0; st_addr = '0; st_data = '0;
    h_addr = '0; h_wdata = '0; h_we = 1'b0;
    for (int i = 0; i < 64; i++) dmem[i] = '0;
    dmem[24] = 32'h7FFF_FFFF;
    forever begin
      @(negedge clk);
      if (dmem_req === 1'b1) begin
        if (dcnt == 0) begin
          h_addr = dmem_addr; h_we = dmem_we; h_wdata = dmem_wdata;
        end else if (dmem_addr !== h_addr || dmem_we !== h_we || dmem_wdata !== h_wdata) begin
          moved = 1'b1;
        end
        if (dcnt >= dmem_delay) begin
          dmem_ready = 1'b1;
          if (dmem_we) begin
            dmem[dmem_addr[7:2]] = dmem_wdata;
            st_addr = dmem_addr;
            st_data = dmem_wdata;
            st_cnt++;
          end else begin
            dmem_rdata = dmem[dmem_addr[7:2]];
          end
          dcnt = 0;
        end else begin
          dmem_ready = 1'b0;
          dcnt++;
        end
      end else begin
        dmem_ready = 1'b0;
        dcnt = 0;
      end
    end
  end

  task automatic clear_imem;
    for (int i = 0; i < 64; i++) imem[i] = enc(5'd31, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic do_reset;
    rst = 1'b0;
    run = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pc",      pc, 32'h4);
    check("rst_flags",   32'(flags), 32'h0);
    check("rst_imem_req", 32'(imem_req), 32'h0);
    check("rst_dmem_req", 32'(dmem_req), 32'h0);
    check("rst_retire",  32'(retire), 32'h0);
    check("rst_illegal", 32'(illegal), 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_run", 32'(imem_req), 32'h0);
    run = 1'b1;
  endtask

  // Returns at the FETCH negedge after the next retire; n = cycles taken.
  task automatic next_instr(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!retire && n < 40);
    if (!retire) check("retire_timeout", 32'(retire), 32'h1);
    @(negedge clk);
    n++;
  endtask

  int n, w, sc;

  initial begin
    rst = 1'b0;
    run = 1'b0;

    // ---------------- segment A: ALU, flags, memory, branches -------------
    clear_imem();
    imem[1]  = enc(5'd5, 4'd1,  4'd0, 4'd0, 1'b1, 1'b0, 12'h005); // MOV r1,#5
    imem[2]  = enc(5'd0, 4'd2,  4'd1, 4'd0, 1'b1, 1'b1, 12'hFFF); // ADDS r2,r1,#FFF
    imem[3]  = enc(5'd5, 4'd3,  4'd0, 4'd0, 1'b1, 1'b0, 12'h000); // MOV r3,#0
    imem[4]  = enc(5'd1, 4'd3,  4'd3, 4'd0, 1'b1, 1'b1, 12'h001); // SUBS r3,r3,#1
    imem[5]  = enc(5'd8, 4'd3,  4'd0, 4'd0, 1'b1, 1'b0, 12'h044); // STR r3,[r0,#44]
    imem[6]  = enc(5'd6, 4'd0,  4'd3, 4'd3, 1'b0, 1'b0, 12'h000); // CMP r3,r3
    imem[7]  = enc(5'd8, 4'd2,  4'd0, 4'd0, 1'b1, 1'b0, 12'h040); // STR r2,[r0,#40]
    imem[8]  = enc(5'd7, 4'd4,  4'd0, 4'd0, 1'b1, 1'b0, 12'h040); // LDR r4,[r0,#40]
    imem[9]  = enc(5'd8, 4'd4,  4'd0, 4'd0, 1'b1, 1'b0, 12'h048); // STR r4,[r0,#48]
    imem[10] = enc(5'd3, 4'd5,  4'd2, 4'd0, 1'b1, 1'b1, 12'h0F0); // ORRS r5,r2,#F0
    imem[11] = enc(5'd8, 4'd5,  4'd0, 4'd0, 1'b1, 1'b0, 12'h04C); // STR r5,[r0,#4C]
    imem[12] = enc(5'd2, 4'd6,  4'd2, 4'd0, 1'b1, 1'b1, 12'h000); // ANDS r6,r2,#0
    imem[13] = enc(5'd0, 4'd7,  4'd3, 4'd3, 1'b0, 1'b1, 12'h000); // ADDS r7,r3,r3
    imem[14] = enc(5'd7, 4'd8,  4'd0, 4'd0, 1'b1, 1'b0, 12'h060); // LDR r8,[r0,#60]
    imem[15] = enc(5'd0, 4'd9,  4'd8, 4'd0, 1'b1, 1'b1, 12'h001); // ADDS r9,r8,#1
    imem[16] = enc(5'd4, 4'd10, 4'd9, 4'd8, 1'b0, 1'b0, 12'h000); // EOR r10,r9,r8
    imem[17] = enc(5'd8, 4'd10, 4'd0, 4'd0, 1'b1, 1'b0, 12'h064); // STR r10,[r0,#64]
    imem[18] = enc(5'd1, 4'd11, 4'd2, 4'd1, 1'b0, 1'b0, 12'h000); // SUB r11,r2,r1
    imem[19] = enc(5'd8, 4'd11, 4'd0, 4'd0, 1'b1, 1'b0, 12'h068); // STR r11,[r0,#68]
    imem[20] = enc_b(5'd9, 23'h7FFFE0);                           // B -32 words
    imem[54] = enc_b(5'd9, 23'h3FFFFF);                           // B +0x3FFFFF
    do_reset();

    next_instr(n);                                  // MOV r1
    check("mov_pc", pc, 32'h8);
    next_instr(n);                                  // ADDS r2
    check("add_cycles", n, 4);
    check("add_flags", 32'(flags), 32'h0);
    check("add_pc", pc, 32'hC);
    run = 1'b0;                                     // MOV r3 already fetching
    next_instr(n);
    check("mov_cycles", n, 4);
    check("norun_pc", pc, 32'h10);
    check("norun_req", 32'(imem_req), 32'h0);
    @(negedge clk);
    check("norun_req_hold", 32'(imem_req), 32'h0);
    check("norun_pc_hold", pc, 32'h10);
    run = 1'b1;
    next_instr(n);                                  // SUBS r3
    check("sub_flags", 32'(flags), 32'h8);
    check("sub_pc", pc, 32'h14);
    next_instr(n);                                  // STR r3
    check("str0_cycles", n, 5);
    check("str0_addr", st_addr, 32'h44);
    check("str0_data", st_data, 32'hFFFF_FFFF);
    check("str0_flags", 32'(flags), 32'h8);
    next_instr(n);                                  // CMP r3,r3
    check("cmp_flags", 32'(flags), 32'h6);
    dmem_delay = 3;
    next_instr(n);                                  // STR r2 (3 waits)
    check("str3_cycles", n, 8);
    check("str3_addr", st_addr, 32'h40);
    check("str3_data", st_data, 32'h1004);
    next_instr(n);                                  // LDR r4 (3 waits)
    check("ldr3_cycles", n, 8);
    check("ldr3_pc", pc, 32'h24);
    dmem_delay = 0;
    next_instr(n);                                  // STR r4
    check("ldr_value", st_data, 32'h1004);
    check("dmem_stable", 32'(moved), 32'h0);
    next_instr(n);                                  // ORRS r5
    check("orr_flags", 32'(flags), 32'h2);
    next_instr(n);                                  // STR r5
    check("orr_value", st_data, 32'h10F4);
    next_instr(n);                                  // ANDS r6
    check("and_flags", 32'(flags), 32'h6);
    next_instr(n);                                  // ADDS r7 carry
    check("addc_flags", 32'(flags), 32'hA);
    next_instr(n);                                  // LDR r8
    check("ldr_keep_flags", 32'(flags), 32'hA);
    next_instr(n);                                  // ADDS r9 overflow
    check("addv_flags", 32'(flags), 32'h9);
    next_instr(n);                                  // EOR r10 (no S)
    check("eor_noflags", 32'(flags), 32'h9);
    next_instr(n);                                  // STR r10
    check("eor_value", st_data, 32'hFFFF_FFFF);
    next_instr(n);                                  // SUB r11 (no S)
    next_instr(n);                                  // STR r11
    check("subreg_value", st_data, 32'h0FFF);
    check("subreg_flags", 32'(flags), 32'h9);
    next_instr(n);                                  // B backwards, wraps
    check("b_cycles", n, 4);
    check("b_wrap_pc", pc, 32'hFFFF_FFD4);
    next_instr(n);                                  // NOP
    check("nop_pc", pc, 32'hFFFF_FFD8);
    check("nop_flags", 32'(flags), 32'h9);
    next_instr(n);                                  // B +0x3FFFFF, wraps
    check("b_fwd_wrap_pc", pc, 32'h00FF_FFD8);

    // ---------------- segment B: BL and reset during a data access --------
    clear_imem();
    imem[1] = enc_b(5'd9, 23'd2);                                  // B +2
    imem[4] = enc_b(5'd10, 23'h7FFFFE);                           // BL -2
    imem[3] = enc(5'd8, 4'd15, 4'd0, 4'd0, 1'b1, 1'b0, 12'h050);  // STR r15,[r0,#50]
    do_reset();
    next_instr(n);
    check("b2_pc", pc, 32'h10);
    next_instr(n);
    check("bl_cycles", n, 4);
    check("bl_pc", pc, 32'hC);
    next_instr(n);
    check("bl_link", st_data, 32'h14);
    check("bl_link_addr", st_addr, 32'h50);
    check("bl_str_pc", pc, 32'h10);
    dmem_delay = 20;
    next_instr(n);
    check("bl2_pc", pc, 32'hC);
    w = 0;
    while (dmem_req !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("mid_req_seen", 32'(dmem_req), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_dmem_req", 32'(dmem_req), 32'h0);
    check("mid_rst_we", 32'(dmem_we), 32'h0);
    check("mid_rst_pc", pc, 32'h4);
    check("mid_rst_retire", 32'(retire), 32'h0);
    run = 1'b0;
    dmem_delay = 0;

    // ---------------- segment C: illegal opcode ---------------------------
    clear_imem();
    imem[1] = enc(5'd5,  4'd1, 4'd0, 4'd0, 1'b1, 1'b0, 12'h007);  // MOV r1,#7
    imem[2] = enc(5'd12, 4'd1, 4'd0, 4'd0, 1'b1, 1'b1, 12'h099);  // undefined
    imem[3] = enc(5'd8,  4'd1, 4'd0, 4'd0, 1'b1, 1'b0, 12'h054);  // STR r1,[r0,#54]
    imem[4] = enc(5'd8,  4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 12'h058);  // STR r2,[r0,#58]
    do_reset();
    next_instr(n);
    check("pre_illegal", 32'(illegal), 32'h0);
    sc = st_cnt;
    next_instr(n);
    check("ill_cycles", n, 4);
    check("ill_flag", 32'(illegal), 32'h1);
    check("ill_pc", pc, 32'hC);
    check("ill_flags", 32'(flags), 32'h0);
    check("ill_no_store", st_cnt, sc);
    next_instr(n);
    check("ill_reg_kept", st_data, 32'h7);
    check("ill_sticky", 32'(illegal), 32'h1);
    next_instr(n);
    check("regs_cleared", st_data, 32'h0);
    check("regs_cleared_addr", st_addr, 32'h58);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
